// File: rtl/ascon_perm_ctrl.sv
// Sequencer for an external 6-stage Ascon round chain: runs pa/pb calls as
// 6-round (fast) or 2-round (compact) passes over a 320-bit state register.
module ascon_perm_ctrl #(
  parameter int unsigned PA_PASSES_FAST = 2,
  parameter int unsigned PB_PASSES_FAST = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [319:0] in_state,
  input  logic         in_pb,
  input  logic         in_fast,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [319:0] out_state,
  input  logic         abort,
  output logic         busy,
  output logic [319:0] chain_x_in,
  output logic [2:0]   chain_loop_num,
  output logic         chain_const_sel,
  output logic [5:0]   chain_enable,
  output logic         chain_compact_fast,
  input  logic [319:0] chain_x_out_6,
  input  logic [319:0] chain_x_out_2
);

  localparam int unsigned STATE_W  = 320;
  localparam int unsigned MAX_FAST = (PA_PASSES_FAST > PB_PASSES_FAST) ? PA_PASSES_FAST
                                                                        : PB_PASSES_FAST;
  localparam int unsigned N_MAX    = 3 * MAX_FAST;
  localparam int unsigned CNT_W    = ($clog2(N_MAX + 1) > 3) ? $clog2(N_MAX + 1) : 3;
  localparam logic [5:0]  EN_FAST    = 6'b111111;
  localparam logic [5:0]  EN_COMPACT = 6'b110000;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e             fsm_q, fsm_d;
  logic [STATE_W-1:0] state_reg_q, state_reg_d;
  logic [CNT_W-1:0]   pass_cnt_q, pass_cnt_d;
  logic               mode_pb_q, mode_pb_d;
  logic               mode_fast_q, mode_fast_d;
  logic               out_valid_q, out_valid_d;
  logic               busy_q, busy_d;
  logic [CNT_W-1:0]   last_pass_c;
  logic               accept_c;

  // Index of the final pass for the latched mode; compact runs 3x the passes.
  always_comb begin
    last_pass_c = '0;
    unique case ({mode_pb_q, mode_fast_q})
      2'b01:   last_pass_c = CNT_W'(PA_PASSES_FAST - 1);
      2'b00:   last_pass_c = CNT_W'(3 * PA_PASSES_FAST - 1);
      2'b11:   last_pass_c = CNT_W'(PB_PASSES_FAST - 1);
      default: last_pass_c = CNT_W'(3 * PB_PASSES_FAST - 1);
    endcase
  end

  assign in_ready = (fsm_q == S_IDLE) | ((fsm_q == S_DONE) & out_ready);
  assign accept_c = in_valid & in_ready;

  // Next-state: abort beats accept, accept beats pass progression.
  always_comb begin
    fsm_d       = fsm_q;
    state_reg_d = state_reg_q;
    pass_cnt_d  = pass_cnt_q;
    mode_pb_d   = mode_pb_q;
    mode_fast_d = mode_fast_q;
    if (abort) begin
      fsm_d = S_IDLE;
    end else if (accept_c) begin
      fsm_d       = S_RUN;
      state_reg_d = in_state;
      pass_cnt_d  = '0;
      mode_pb_d   = in_pb;
      mode_fast_d = in_fast;
    end else if (fsm_q == S_RUN) begin
      state_reg_d = mode_fast_q ? chain_x_out_6 : chain_x_out_2;
      pass_cnt_d  = pass_cnt_q + CNT_W'(1);
      if (pass_cnt_q == last_pass_c) begin
        fsm_d = S_DONE;
      end
    end else if ((fsm_q == S_DONE) && out_ready) begin
      fsm_d = S_IDLE;
    end
    out_valid_d = (fsm_d == S_DONE);
    busy_d      = (fsm_d == S_RUN);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_q       <= S_IDLE;
      state_reg_q <= '0;
      pass_cnt_q  <= '0;
      mode_pb_q   <= 1'b0;
      mode_fast_q <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      fsm_q       <= fsm_d;
      state_reg_q <= state_reg_d;
      pass_cnt_q  <= pass_cnt_d;
      mode_pb_q   <= mode_pb_d;
      mode_fast_q <= mode_fast_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign out_valid          = out_valid_q;
  assign busy               = busy_q;
  assign out_state          = state_reg_q;
  assign chain_x_in         = state_reg_q;
  assign chain_loop_num     = pass_cnt_q[2:0];
  assign chain_const_sel    = mode_pb_q;
  assign chain_compact_fast = mode_fast_q;
  assign chain_enable       = mode_fast_q ? EN_FAST : EN_COMPACT;

endmodule
